run_detector: RTL and testbench
===============================

RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter RUN_W, default 4: width of run-length counter and threshold; max run = 2^RUN_W-1.
REQ-002 Parameter CNT_W, default 8: width of match event counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  qualifies in; when low the cycle is ignored.
REQ-006 in  input  1  serial data bit.
REQ-007 polarity  input  1  bit value whose runs are detected (1 = runs of ones, 0 = runs of zeros).
REQ-008 threshold  input  RUN_W  run length N that constitutes a match; legal 1..2^RUN_W-1.
REQ-009 mode  input  2  00 level, 01 pulse, 10 retrigger, 11 reserved (behaves as level).
REQ-010 clr_count  input  1  synchronous clear of match_count.
REQ-011 out  output  1  registered match indication per mode.
REQ-012 run_len  output  RUN_W  current saturating run length.
REQ-013 match_count  output  CNT_W  saturating count of match events.
REQ-014 cfg_err  output  1  registered flag, high while threshold == 0.

Function
REQ-015 On a valid cycle with in == polarity, run_len SHALL increment, saturating at 2^RUN_W-1.
REQ-016 On a valid cycle with in != polarity, run_len SHALL become 0.
REQ-017 On an invalid cycle, run_len, the segment counter and match_count SHALL hold.
REQ-018 Latency: out SHALL reflect the run_len value loaded on the same edge, so out rises in the cycle after the Nth qualifying bit is sampled.
REQ-019 Level mode: out SHALL be 1 exactly while run_len >= threshold, including while run_len is saturated.
REQ-020 Pulse mode: out SHALL be a single-cycle 1 on the valid edge where run_len becomes equal to threshold; 0 at all other times.
REQ-021 Retrigger mode: an internal segment counter SHALL count qualifying bits; on reaching threshold, out pulses for one cycle and the segment counter returns to 0 (non-overlapping matches).
REQ-022 The segment counter SHALL clear on a run break and whenever mode != 10.
REQ-023 In pulse and retrigger modes, out SHALL be 0 during invalid cycles.
REQ-024 In level mode, out SHALL hold during invalid cycles.
REQ-025 A match event SHALL be: each out pulse in pulse or retrigger mode, or each 0->1 transition of out in level mode.
REQ-026 match_count SHALL increment by 1 per match event, saturating at 2^CNT_W-1.
REQ-027 clr_count SHALL have priority over a simultaneous match event; match_count becomes 0 and that event is not counted.
REQ-028 threshold == 0: cfg_err = 1, out forced 0, no match events; run_len still tracks.
REQ-029 threshold, mode and polarity SHALL be sampled every cycle without clearing run_len; a change takes effect at the next edge.

Reset
REQ-030 Reset SHALL force run_len = 0, segment counter = 0, out = 0, match_count = 0.
REQ-031 cfg_err SHALL be 0 on reset and update from threshold on the first edge after reset deasserts.
REQ-032 Reset SHALL override in_valid, clr_count and all data inputs on the same edge.
REQ-033 Reset mid-run SHALL discard the run; detection restarts from 0 qualifying bits.

Structure
REQ-034 Package run_detector_pkg SHALL hold the mode encodings (MODE_LEVEL, MODE_PULSE, MODE_RETRIG) and the reserved-mode decode rule.
REQ-035 One sub-module, sat_counter (parametrised width; inc and clr inputs; saturating), SHALL be instanced for run_len and for match_count.

Verification
REQ-036 Level mode, N=3, polarity=1, in=1,1,1,1,0 all valid: out = 0,0,0,1,1 then 0 after the 0 is sampled; match_count = 1.
REQ-037 Retrigger mode, N=3, seven consecutive valid ones: out pulses after bits 3 and 6; match_count = 2; run_len = 7.
REQ-038 Pulse mode, RUN_W=4, N=15, twenty ones: run_len saturates at 15; exactly one pulse; no wrap to 0.
REQ-039 Pulse mode, N=2, ones with in_valid low between them: bits 1,(gap),1 produce one pulse; out is 0 during the gap.
REQ-040 clr_count asserted on the same edge as a match event with match_count=5: match_count = 0.
REQ-041 threshold=0, any stream: cfg_err = 1, out stays 0; reset asserted mid-run with run_len=2: run_len = 0 next cycle.

Source files
------------

// File: rtl/run_detector_pkg.sv
// Shared definitions for the run-length detector: mode encodings and the
// rule that folds the reserved mode onto level behaviour.
package run_detector_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_RETRIG = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Map the raw mode input onto the behaviour actually implemented;
    // the reserved encoding behaves exactly like level mode.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b01:   m = MODE_PULSE;
            2'b10:   m = MODE_RETRIG;
            default: m = MODE_LEVEL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear. Reset beats clear, clear
// beats increment, and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    logic [W-1:0] r_cnt;

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= CNT_ZERO;
        end else if (i_clr) begin
            r_cnt <= CNT_ZERO;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/run_detector.sv
// Serial run-length detector: tracks the current run of the selected bit
// value, flags matches against a threshold in level, pulse or retrigger
// mode, and counts match events in a saturating counter.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int RUN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             polarity,
    input  logic [RUN_W-1:0] threshold,
    input  logic [1:0]       mode,
    input  logic             clr_count,
    output logic             out,
    output logic [RUN_W-1:0] run_len,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};

    logic             r_out;
    logic [RUN_W-1:0] r_seg;
    logic             r_cfg_err;

    logic             w_qual;
    logic             w_break;
    logic             w_thr_zero;
    mode_e            w_mode;
    logic [RUN_W-1:0] w_run_next;
    logic [RUN_W:0]   w_seg_inc;
    logic             w_out_raw;
    logic             w_event_raw;
    logic [RUN_W-1:0] w_seg_raw;
    logic             w_out_next;
    logic             w_event;
    logic [RUN_W-1:0] w_seg_next;

    assign w_qual     = in_valid && (in == polarity);
    assign w_break    = in_valid && (in != polarity);
    assign w_thr_zero = (threshold == RUN_ZERO);
    assign w_mode     = decode_mode(mode);

    // Run length as it will be after this edge; the match decision is made
    // against this so out lines up with the run_len loaded on the same edge.
    always_comb begin
        w_run_next = run_len;
        if (w_qual) begin
            w_run_next = (run_len == RUN_MAX) ? RUN_MAX : (run_len + RUN_W'(1));
        end else if (w_break) begin
            w_run_next = RUN_ZERO;
        end else begin
            w_run_next = run_len;
        end
    end

    // Per-mode match decision and segment-counter update.
    always_comb begin
        w_out_raw   = 1'b0;
        w_event_raw = 1'b0;
        w_seg_raw   = RUN_ZERO;
        w_seg_inc   = {1'b0, r_seg} + (RUN_W + 1)'(1);
        case (w_mode)
            MODE_PULSE: begin
                // Only the edge where the run first reaches N, so a run
                // saturated at N does not keep pulsing.
                w_out_raw   = w_qual && (w_run_next == threshold) && (run_len != threshold);
                w_event_raw = w_out_raw;
            end
            MODE_RETRIG: begin
                if (!in_valid) begin
                    w_seg_raw = r_seg;
                end else if (w_qual) begin
                    // >= rather than == so a threshold lowered below the
                    // current segment fires immediately instead of wrapping.
                    if (w_seg_inc >= {1'b0, threshold}) begin
                        w_out_raw = 1'b1;
                        w_seg_raw = RUN_ZERO;
                    end else begin
                        w_seg_raw = w_seg_inc[RUN_W-1:0];
                    end
                end else begin
                    w_seg_raw = RUN_ZERO;
                end
                w_event_raw = w_out_raw;
            end
            default: begin
                // Level: invalid cycles hold the indication.
                w_out_raw   = in_valid ? (w_run_next >= threshold) : r_out;
                w_event_raw = w_out_raw && !r_out;
            end
        endcase
        // A zero threshold is a configuration error: no matches, no segment.
        w_out_next = w_thr_zero ? 1'b0 : w_out_raw;
        w_event    = w_thr_zero ? 1'b0 : w_event_raw;
        w_seg_next = w_thr_zero ? RUN_ZERO : w_seg_raw;
    end

    // Registered match indication, segment counter and config error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= 1'b0;
            r_seg     <= RUN_ZERO;
            r_cfg_err <= 1'b0;
        end else begin
            r_out     <= w_out_next;
            r_seg     <= w_seg_next;
            r_cfg_err <= w_thr_zero;
        end
    end

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_qual),
        .i_clr (w_break),
        .o_cnt (run_len)
    );

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_event),
        .i_clr (clr_count),
        .o_cnt (match_count)
    );

    assign out     = r_out;
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector: a behavioural model predicts every
// output per cycle, predictions go into a scoreboard queue when stimulus is
// driven and are popped and compared after the DUT's edge.
module tb_run_detector;

    localparam int RUN_W = 4;
    localparam int CNT_W = 8;
    localparam int RUN_MAX = 15;
    localparam int CNT_MAX = 255;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in;
    logic             polarity;
    logic [RUN_W-1:0] threshold;
    logic [1:0]       mode;
    logic             clr_count;
    logic             out;
    logic [RUN_W-1:0] run_len;
    logic [CNT_W-1:0] match_count;
    logic             cfg_err;

    typedef struct {
        int e_out;
        int e_run;
        int e_cnt;
        int e_cfg;
    } exp_t;

    exp_t sb_q[$];

    int n_tests;
    int n_fail;

    // Model state
    int m_run, m_seg, m_out, m_cnt, m_cfg;

    run_detector #(.RUN_W(RUN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in          (in),
        .polarity    (polarity),
        .threshold   (threshold),
        .mode        (mode),
        .clr_count   (clr_count),
        .out         (out),
        .run_len     (run_len),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Model of one clock edge with the given inputs.
    task automatic model_edge(input int rst, input int v, input int b, input int pol,
                              input int thr, input int md, input int clr);
        int qual, brk, nrun, eff, nout, nseg, ev;
        if (rst != 0) begin
            m_run = 0; m_seg = 0; m_out = 0; m_cnt = 0; m_cfg = 0;
        end else begin
            qual = (v != 0) && (b == pol);
            brk  = (v != 0) && (b != pol);
            nrun = qual ? ((m_run < RUN_MAX) ? m_run + 1 : RUN_MAX) : (brk ? 0 : m_run);
            eff  = (md == 3) ? 0 : md;
            nout = 0; nseg = 0; ev = 0;
            if (thr == 0) begin
                nout = 0; nseg = 0; ev = 0;
            end else if (eff == 0) begin
                nout = (v != 0) ? ((nrun >= thr) ? 1 : 0) : m_out;
                ev   = (nout == 1 && m_out == 0) ? 1 : 0;
            end else if (eff == 1) begin
                nout = (qual && nrun == thr && m_run != thr) ? 1 : 0;
                ev   = nout;
            end else begin
                if (v == 0) nseg = m_seg;
                else if (brk) nseg = 0;
                else if (m_seg + 1 >= thr) begin nout = 1; nseg = 0; ev = 1; end
                else nseg = m_seg + 1;
            end
            if (clr != 0) m_cnt = 0;
            else if (ev != 0) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_cfg = (thr == 0) ? 1 : 0;
            m_run = nrun; m_out = nout; m_seg = nseg;
        end
    endtask

    // Drive one cycle, push the prediction, then pop and compare after the edge.
    task automatic step(input int rst, input int v, input int b, input int pol,
                        input int thr, input int md, input int clr);
        exp_t e;
        reset     = rst[0];
        in_valid  = v[0];
        in        = b[0];
        polarity  = pol[0];
        threshold = thr[RUN_W-1:0];
        mode      = md[1:0];
        clr_count = clr[0];
        model_edge(rst, v, b, pol, thr, md, clr);
        e.e_out = m_out; e.e_run = m_run; e.e_cnt = m_cnt; e.e_cfg = m_cfg;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_value("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_value("out", int'(out), e.e_out);
            check_value("run_len", int'(run_len), e.e_run);
            check_value("match_count", int'(match_count), e.e_cnt);
            check_value("cfg_err", int'(cfg_err), e.e_cfg);
        end
    endtask

    task automatic do_reset(input int thr);
        step(1, 1, 1, 1, thr, 0, 1);
        step(1, 0, 0, 1, thr, 0, 0);
    endtask

    initial begin
        int pol_r, md_r, thr_r;
        n_tests = 0; n_fail = 0;
        m_run = 0; m_seg = 0; m_out = 0; m_cnt = 0; m_cfg = 0;
        reset = 1'b1; in_valid = 1'b0; in = 1'b0; polarity = 1'b1;
        threshold = 4'd3; mode = 2'b00; clr_count = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, with threshold 0 so cfg_err must still read 0.
        do_reset(0);
        check_value("rst_out", int'(out), 0);
        check_value("rst_cfg", int'(cfg_err), 0);

        // Level mode N=3: 1,1,1,1,0
        do_reset(3);
        step(0, 1, 1, 1, 3, 0, 0);
        step(0, 1, 1, 1, 3, 0, 0);
        step(0, 1, 1, 1, 3, 0, 0);
        check_value("lvl_rise", int'(out), 1);
        step(0, 1, 1, 1, 3, 0, 0);
        step(0, 1, 0, 1, 3, 0, 0);
        check_value("lvl_fall", int'(out), 0);
        check_value("lvl_cnt", int'(match_count), 1);

        // Retrigger N=3, seven ones
        do_reset(3);
        repeat (7) step(0, 1, 1, 1, 3, 2, 0);
        check_value("rtg_cnt", int'(match_count), 2);
        check_value("rtg_run", int'(run_len), 7);

        // Pulse N=15, twenty ones: saturate, one pulse
        do_reset(15);
        repeat (20) step(0, 1, 1, 1, 15, 1, 0);
        check_value("pls_sat_run", int'(run_len), 15);
        check_value("pls_sat_cnt", int'(match_count), 1);

        // Pulse N=2 with an invalid gap
        do_reset(2);
        step(0, 1, 1, 1, 2, 1, 0);
        step(0, 0, 1, 1, 2, 1, 0);
        check_value("gap_out", int'(out), 0);
        step(0, 1, 1, 1, 2, 1, 0);
        check_value("gap_pulse", int'(out), 1);
        check_value("gap_cnt", int'(match_count), 1);

        // clr_count on the same edge as a match event with count 5
        do_reset(1);
        repeat (5) begin
            step(0, 1, 1, 1, 1, 1, 0);
            step(0, 1, 0, 1, 1, 1, 0);
        end
        check_value("clr_pre", int'(match_count), 5);
        step(0, 1, 1, 1, 1, 1, 1);
        check_value("clr_prio", int'(match_count), 0);

        // Zero threshold, then reset mid-run
        do_reset(0);
        repeat (6) step(0, 1, 1, 1, 0, 0, 0);
        check_value("thr0_cfg", int'(cfg_err), 1);
        check_value("thr0_out", int'(out), 0);
        check_value("thr0_run", int'(run_len), 6);
        do_reset(3);
        step(0, 1, 0, 0, 3, 0, 0);
        step(0, 1, 0, 0, 3, 0, 0);
        check_value("mid_run2", int'(run_len), 2);
        step(1, 1, 0, 0, 3, 0, 0);
        check_value("mid_rst", int'(run_len), 0);

        // match_count saturation at 255
        do_reset(1);
        repeat (260) begin
            step(0, 1, 1, 1, 1, 1, 0);
            step(0, 1, 0, 1, 1, 1, 0);
        end
        check_value("cnt_sat", int'(match_count), 255);

        // Random traffic across modes, thresholds, polarity and resets
        do_reset(3);
        pol_r = 1; md_r = 0; thr_r = 3;
        for (int i = 0; i < 600; i++) begin
            if ((i % 20) == 0) begin
                md_r  = $urandom_range(0, 3);
                thr_r = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
                if ($urandom_range(0, 3) == 0) pol_r = 1 - pol_r;
            end
            step(($urandom_range(0, 79) == 0) ? 1 : 0,
                 ($urandom_range(0, 4) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? pol_r : 1 - pol_r,
                 pol_r, thr_r, md_r,
                 ($urandom_range(0, 59) == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
